// File: rtl/mmu_ctrl.sv
// mmu_ctrl: sequencer for the 2x2 systolic matrix unit.
// Loads the four weights from the two weight FIFOs with a staggered column-capture
// schedule, then streams a tile of activation vectors from the unified buffer with
// one-cycle row skew and flags each column's valid accumulator output.
// Build option: define MMU_CTRL_WEIGHT_REUSE_EN to honour reuse_w (skip LOAD).
module mmu_ctrl #(
  parameter int unsigned MAX_VEC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_vec,
  input  logic       reuse_w,
  output logic       busy,
  output logic       done,
  input  logic       wf0_empty,
  input  logic       wf1_empty,
  output logic       wf0_pop,
  output logic       wf1_pop,
  output logic       en_weight_pass,
  output logic       en_capture_col0,
  output logic       en_capture_col1,
  output logic       ub_rd_en0,
  output logic       ub_rd_en1,
  output logic [7:0] ub_addr0,
  output logic [7:0] ub_addr1,
  output logic       acc_valid0,
  output logic       acc_valid1,
  output logic [7:0] acc_idx0,
  output logic [7:0] acc_idx1
);

  localparam int unsigned VW = $clog2(MAX_VEC + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]      state, state_nxt;
  logic [1:0]      step, step_nxt;
  logic [VW-1:0]   vec_cnt, vec_cnt_nxt;
  logic [VW-1:0]   nv, nv_nxt;
  logic [VW-1:0]   nv_clamped;
  logic            reuse_ok;
  logic            step_ok;

  // Read-strobe delay line: [0] = row-1 read, [2] = col-0 result, [3] = col-1 result.
  logic [3:0]      v_pipe;
  logic [3:0][7:0] a_pipe;

`ifdef MMU_CTRL_WEIGHT_REUSE_EN
  assign reuse_ok = reuse_w;
`else
  logic unused_reuse_w;
  assign unused_reuse_w = reuse_w;
  assign reuse_ok       = 1'b0;
`endif

  // Clamp the requested tile length to what the counter can hold.
  always_comb begin
    nv_clamped = VW'(num_vec);
    if (32'(num_vec) > MAX_VEC) nv_clamped = VW'(MAX_VEC);
  end

  // FIFO availability required by the current LOAD step.
  always_comb begin
    step_ok = 1'b0;
    case (step)
      2'd0:    step_ok = !wf0_empty;
      2'd1:    step_ok = !wf0_empty && !wf1_empty;
      2'd2:    step_ok = !wf1_empty;
      default: step_ok = 1'b0;
    endcase
  end

  // Next-state logic for the sequencer FSM and its counters.
  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    vec_cnt_nxt = vec_cnt;
    nv_nxt      = nv;
    case (state)
      IDLE: begin
        if (start) begin
          nv_nxt   = nv_clamped;
          step_nxt = 2'd0;
          if (reuse_ok) state_nxt = (nv_clamped == '0) ? DONE : STREAM;
          else          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (step_ok) begin
          if (step == 2'd2) begin
            step_nxt  = 2'd0;
            state_nxt = (nv == '0) ? DONE : STREAM;
          end else begin
            step_nxt = step + 2'd1;
          end
        end
      end
      STREAM: begin
        if (vec_cnt == nv - VW'(1)) begin
          vec_cnt_nxt = '0;
          state_nxt   = DRAIN;
        end else begin
          vec_cnt_nxt = vec_cnt + VW'(1);
        end
      end
      DRAIN: begin
        // Leave once the final col-1 result is out and nothing is behind it.
        if (v_pipe[3] && (v_pipe[2:0] == 3'b000)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      step    <= 2'd0;
      vec_cnt <= '0;
      nv      <= '0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      vec_cnt <= vec_cnt_nxt;
      nv      <= nv_nxt;
    end
  end

  // Weight-load controls; all held low while a step stalls.
  always_comb begin
    wf0_pop         = 1'b0;
    wf1_pop         = 1'b0;
    en_weight_pass  = 1'b0;
    en_capture_col0 = 1'b0;
    en_capture_col1 = 1'b0;
    if (state == LOAD && step_ok) begin
      case (step)
        2'd0: begin
          wf0_pop        = 1'b1;
          en_weight_pass = 1'b1;
        end
        2'd1: begin
          wf0_pop         = 1'b1;
          wf1_pop         = 1'b1;
          en_weight_pass  = 1'b1;
          en_capture_col0 = 1'b1;
        end
        2'd2: begin
          wf1_pop         = 1'b1;
          en_weight_pass  = 1'b1;
          en_capture_col1 = 1'b1;
        end
        default: begin
          wf0_pop = 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign ub_rd_en0 = (state == STREAM);
  assign ub_addr0  = ub_rd_en0 ? 8'(vec_cnt) : 8'd0;

  // Delay line on the row-0 read strobe; idle slots carry index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_pipe <= '0;
      a_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[2:0], ub_rd_en0};
      a_pipe <= {a_pipe[2:0], ub_addr0};
    end
  end

  assign ub_rd_en1  = v_pipe[0];
  assign ub_addr1   = a_pipe[0];
  assign acc_valid0 = v_pipe[2];
  assign acc_idx0   = a_pipe[2];
  assign acc_valid1 = v_pipe[3];
  assign acc_idx1   = a_pipe[3];

endmodule
